// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: decoder flags, memory handshakes and datapath controls of the sequencer
interface instr_sequencer_if #(parameter int RET_W = 16);
  logic run, step, imem_ready, dmem_ready;
  logic ins_add, ins_sub, ins_sw, ins_lw, ins_addi, ins_lui, ins_jal;
  logic [1:0] cnt_set;
  logic stop;
  logic imem_req, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0] wb_sel;
  logic alu_sub, alu_imm, dmem_re, dmem_we;
  logic busy, halted, bus_err;
  logic [RET_W-1:0] retired;
  modport master (
    input  run, step, imem_ready, dmem_ready,
    input  ins_add, ins_sub, ins_sw, ins_lw, ins_addi, ins_lui, ins_jal, cnt_set, stop,
    output imem_req, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_sub, alu_imm,
    output dmem_re, dmem_we, busy, halted, bus_err, retired
  );
  modport slave (
    output run, step, imem_ready, dmem_ready,
    output ins_add, ins_sub, ins_sw, ins_lw, ins_addi, ins_lui, ins_jal, cnt_set, stop,
    input  imem_req, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_sub, alu_imm,
    input  dmem_re, dmem_we, busy, halted, bus_err, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the single-cycle decoder.
// SINGLE_STEP_EN adds a PAUSE state after each retire, released by step.
module instr_sequencer #(
  parameter int RET_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  instr_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, RETIRE, HALT
`ifdef SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;
  localparam int C_ADD = 0, C_SUB = 1, C_SW = 2, C_LW = 3, C_ADDI = 4, C_LUI = 5, C_JAL = 6;
`ifdef SINGLE_STEP_EN
  localparam state_t AFTER_RETIRE = PAUSE;
`else
  localparam state_t AFTER_RETIRE = FETCH;
  logic unused_step;
  assign unused_step = bus.step;
`endif
  state_t state;
  logic [6:0] cls;
  logic [1:0] exec_cnt;
  logic [7:0] wait_cnt;
  logic [RET_W-1:0] ret_q;
  logic bus_err_q;
  logic [6:0] flags;
  assign flags = {bus.ins_jal, bus.ins_lui, bus.ins_addi, bus.ins_lw, bus.ins_sw, bus.ins_sub, bus.ins_add};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cls <= '0;
      exec_cnt <= '0;
      wait_cnt <= '0;
      ret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.run) state <= FETCH;
        FETCH: if (bus.imem_ready) state <= DECODE;
        DECODE: begin
          // several flags at once is an illegal decode, handled like an unknown opcode
          if (bus.stop || !$onehot(flags)) state <= HALT;
          else begin
            cls <= flags;
            exec_cnt <= bus.cnt_set;
            state <= EXEC;
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          if (exec_cnt == 2'd0) state <= (cls[C_LW] || cls[C_SW]) ? MEM : WB;
          else exec_cnt <= exec_cnt - 2'd1;
        end
        MEM: begin
          if (bus.dmem_ready) state <= cls[C_LW] ? WB : RETIRE;
          else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            bus_err_q <= 1'b1;
            state <= HALT;
          end else wait_cnt <= wait_cnt + 8'd1;
        end
        WB, RETIRE: begin
          ret_q <= ret_q + RET_W'(1);
          state <= AFTER_RETIRE;
        end
`ifdef SINGLE_STEP_EN
        PAUSE: if (bus.step) state <= FETCH;
`endif
        default: state <= HALT;
      endcase
    end
  end
  always_comb begin
    bus.imem_req = state == FETCH;
    bus.ir_we = state == FETCH && bus.imem_ready;
    bus.reg_we = state == WB;
    bus.pc_we = state == WB || state == RETIRE;
    bus.pc_sel = state == WB && cls[C_JAL];
    bus.wb_sel = state != WB ? 2'd0 : cls[C_JAL] ? 2'd3 : cls[C_LUI] ? 2'd2 : cls[C_LW] ? 2'd1 : 2'd0;
    bus.alu_sub = state == EXEC && cls[C_SUB];
    bus.alu_imm = state == EXEC && (cls[C_ADDI] || cls[C_LW] || cls[C_SW]);
    bus.dmem_re = state == MEM && cls[C_LW];
    bus.dmem_we = state == MEM && cls[C_SW];
    bus.busy = state != IDLE && state != HALT;
    bus.halted = state == HALT;
    bus.bus_err = bus_err_q;
    bus.retired = ret_q;
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; expected writeback/retire controls are queued per instruction
module tb_instr_sequencer;
`ifdef SINGLE_STEP_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_wb;
  instr_sequencer_if bus();
  instr_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    if (!rst && (bus.pc_we || bus.reg_we)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected got reg_we/wb_sel/pc_sel=%b", {bus.reg_we, bus.wb_sel, bus.pc_sel});
      end else begin
        exp_wb = sb.pop_front();
        if ({bus.reg_we, bus.wb_sel, bus.pc_sel} !== exp_wb) begin
          errors++;
          $display("FAIL retire_ctrl got %b expected %b", {bus.reg_we, bus.wb_sel, bus.pc_sel}, exp_wb);
        end
      end
    end
  end
  function automatic logic [13:0] outs();
    return {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.reg_we, bus.wb_sel,
            bus.alu_sub, bus.alu_imm, bus.dmem_re, bus.dmem_we, bus.busy, bus.halted, bus.bus_err};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_flags();
    {bus.ins_add, bus.ins_sub, bus.ins_sw, bus.ins_lw, bus.ins_addi, bus.ins_lui, bus.ins_jal, bus.stop} = '0;
    bus.cnt_set = 2'd0;
  endtask
  task automatic wait_fetch();
    for (int n = 0; n < 32 && !bus.imem_req; n++) begin
      tick();
      #1;
    end
    if (!bus.imem_req) begin
      $display("FAIL fetch_timeout imem_req never asserted");
      $fatal(1, "fetch timeout");
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    #1;
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL reset_outputs got %b expected 0", outs()); end
    checks++;
    if (bus.retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d expected 0", bus.retired); end
    rst = 1'b0;
  endtask
  task automatic test_add();
    clear_flags();
    bus.ins_add = 1'b1;
    sb.push_back({1'b1, 2'd0, 1'b0});
    tick();
    bus.run = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.imem_req} !== 2'b00) begin errors++; $display("FAIL add_idle got %b expected 00", {bus.busy, bus.imem_req}); end
    tick();
    #1;
    checks++;
    if ({bus.imem_req, bus.ir_we} !== 2'b11) begin errors++; $display("FAIL add_fetch got %b expected 11", {bus.imem_req, bus.ir_we}); end
    tick();
    bus.imem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.ir_we, bus.imem_req} !== 3'b100) begin errors++; $display("FAIL add_decode got %b expected 100", {bus.busy, bus.ir_we, bus.imem_req}); end
    tick();
    #1;
    checks++;
    if ({bus.reg_we, bus.pc_we, bus.alu_sub, bus.alu_imm} !== 4'b0000) begin errors++; $display("FAIL add_exec got %b expected 0000", {bus.reg_we, bus.pc_we, bus.alu_sub, bus.alu_imm}); end
    tick();
    #1;
    checks++;
    if ({bus.reg_we, bus.pc_we, bus.wb_sel} !== 4'b1100) begin errors++; $display("FAIL add_wb got %b expected 1100", {bus.reg_we, bus.pc_we, bus.wb_sel}); end
    tick();
    #1;
    checks++;
    if (bus.retired !== 16'd1) begin errors++; $display("FAIL add_retired got %0d expected 1", bus.retired); end
    repeat (P) begin tick(); #1; end
    checks++;
    if ({bus.imem_req, bus.ir_we} !== 2'b10) begin errors++; $display("FAIL add_next_fetch got %b expected 10", {bus.imem_req, bus.ir_we}); end
  endtask
  task automatic test_lw();
    clear_flags();
    bus.ins_lw = 1'b1;
    bus.cnt_set = 2'd1;
    sb.push_back({1'b1, 2'd1, 1'b0});
    wait_fetch();
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (bus.ir_we !== 1'b1) begin errors++; $display("FAIL lw_fetch ir_we got %b expected 1", bus.ir_we); end
    tick();
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      checks++;
      if ({bus.alu_imm, bus.alu_sub, bus.dmem_re} !== 3'b100) begin errors++; $display("FAIL lw_exec%0d got %b expected 100", k, {bus.alu_imm, bus.alu_sub, bus.dmem_re}); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.dmem_ready = (k == 2);
      #1;
      checks++;
      if ({bus.dmem_re, bus.dmem_we, bus.reg_we} !== 3'b100) begin errors++; $display("FAIL lw_mem%0d got %b expected 100", k, {bus.dmem_re, bus.dmem_we, bus.reg_we}); end
    end
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.dmem_re, bus.reg_we, bus.wb_sel} !== 4'b0101) begin errors++; $display("FAIL lw_wb got %b expected 0101", {bus.dmem_re, bus.reg_we, bus.wb_sel}); end
    tick();
    #1;
    checks++;
    if (bus.retired !== 16'd2) begin errors++; $display("FAIL lw_retired got %0d expected 2", bus.retired); end
  endtask
  task automatic test_jal_halt();
    clear_flags();
    bus.ins_jal = 1'b1;
    sb.push_back({1'b1, 2'd3, 1'b1});
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if ({bus.reg_we, bus.pc_we, bus.pc_sel, bus.wb_sel} !== 5'b11111) begin errors++; $display("FAIL jal_wb got %b expected 11111", {bus.reg_we, bus.pc_we, bus.pc_sel, bus.wb_sel}); end
    clear_flags();
    bus.stop = 1'b1;
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.halted} !== 2'b10) begin errors++; $display("FAIL stop_decode got %b expected 10", {bus.busy, bus.halted}); end
    tick();
    #1;
    checks++;
    if ({bus.busy, bus.halted} !== 2'b01) begin errors++; $display("FAIL stop_halt got %b expected 01", {bus.busy, bus.halted}); end
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    repeat (2) tick();
    #1;
    checks++;
    if ({bus.halted, bus.busy, bus.imem_req, bus.bus_err} !== 4'b1000) begin errors++; $display("FAIL halt_sticky got %b expected 1000", {bus.halted, bus.busy, bus.imem_req, bus.bus_err}); end
    checks++;
    if (bus.retired !== 16'd3) begin errors++; $display("FAIL halt_retired got %0d expected 3", bus.retired); end
  endtask
  task automatic test_rst_mid_mem();
    rst = 1'b1;
    bus.run = 1'b0;
    clear_flags();
    repeat (2) tick();
    rst = 1'b0;
    bus.ins_add = 1'b1;
    sb.push_back({1'b1, 2'd0, 1'b0});
    bus.run = 1'b1;
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    repeat (3) tick();
    #1;
    checks++;
    if (bus.retired !== 16'd1) begin errors++; $display("FAIL b2b_retired got %0d expected 1", bus.retired); end
    clear_flags();
    bus.ins_lw = 1'b1;
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    repeat (2) tick();
    #1;
    checks++;
    if (bus.dmem_re !== 1'b1) begin errors++; $display("FAIL rst_mem_entry dmem_re got %b expected 1", bus.dmem_re); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.run = 1'b0;
    #1;
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL rst_mem_outputs got %b expected 0", outs()); end
    checks++;
    if (bus.retired !== 16'd0) begin errors++; $display("FAIL rst_mem_retired got %0d expected 0", bus.retired); end
    tick();
    #1;
    checks++;
    if ({bus.busy, bus.reg_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_idle got %b expected 00", {bus.busy, bus.reg_we}); end
  endtask
  task automatic test_sw_boundary();
    int n;
    n = 0;
    clear_flags();
    bus.ins_sw = 1'b1;
    sb.push_back({1'b0, 2'd0, 1'b0});
    bus.run = 1'b1;
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      bus.dmem_ready = (k == 15);
      #1;
      n += int'(bus.dmem_we);
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL sw_edge_mem_cycles got %0d expected 16", n); end
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.pc_we, bus.reg_we, bus.bus_err, bus.halted} !== 4'b1000) begin errors++; $display("FAIL sw_edge_retire got %b expected 1000", {bus.pc_we, bus.reg_we, bus.bus_err, bus.halted}); end
    tick();
    #1;
    checks++;
    if (bus.retired !== 16'd1) begin errors++; $display("FAIL sw_edge_retired got %0d expected 1", bus.retired); end
  endtask
  task automatic test_sw_timeout();
    int n;
    n = 0;
    clear_flags();
    bus.ins_sw = 1'b1;
    wait_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      #1;
      if (!bus.dmem_we) break;
      n++;
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL sw_timeout_cycles got %0d expected 16", n); end
    checks++;
    if ({bus.bus_err, bus.halted, bus.busy} !== 3'b110) begin errors++; $display("FAIL sw_timeout_flags got %b expected 110", {bus.bus_err, bus.halted, bus.busy}); end
    checks++;
    if (bus.retired !== 16'd1) begin errors++; $display("FAIL sw_timeout_retired got %0d expected 1", bus.retired); end
  endtask
`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    rst = 1'b1;
    bus.step = 1'b0;
    clear_flags();
    bus.ins_addi = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.run = 1'b1;
    bus.imem_ready = 1'b1;
    sb.push_back({1'b1, 2'd0, 1'b0});
    sb.push_back({1'b1, 2'd0, 1'b0});
    repeat (10) tick();
    #1;
    checks++;
    if ({bus.retired, bus.busy, bus.imem_req} !== {16'd1, 2'b10}) begin errors++; $display("FAIL step_pause got retired=%0d busy=%b req=%b expected 1 1 0", bus.retired, bus.busy, bus.imem_req); end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    repeat (10) tick();
    #1;
    checks++;
    if ({bus.retired, bus.busy, bus.imem_req} !== {16'd2, 2'b10}) begin errors++; $display("FAIL step_one got retired=%0d busy=%b req=%b expected 2 1 0", bus.retired, bus.busy, bus.imem_req); end
    bus.imem_ready = 1'b0;
  endtask
`endif
  initial begin
    bus.run = 1'b0;
    bus.step = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    clear_flags();
    test_reset();
    test_add();
    test_lw();
    test_jal_halt();
    test_rst_mid_mem();
    test_sw_boundary();
    test_sw_timeout();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d pending expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
